// File: rtl/bmem_responder.sv
// bmem burst responder: serves one line-sized read or write as BURST_LEN 64-bit beats after LATENCY cycles.
// Optional address range check: define BMEM_ADDR_CHECK_EN (out-of-range bursts flag bmem_err and touch no storage).
module bmem_responder #(
    parameter int LATENCY     = 4,
    parameter int BURST_LEN   = 4,
    parameter int DEPTH_LINES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_address,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic [63:0] bmem_rdata,
    output logic        bmem_resp,
    output logic        bmem_err
);

    localparam int OFF  = $clog2(BURST_LEN * 8);
    localparam int IDXW = $clog2(DEPTH_LINES);
    localparam int BCW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LCW  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int MEMW = IDXW + $clog2(BURST_LEN);
    localparam logic [63:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_e;

    state_e          state_q;
    logic [IDXW-1:0] idx_q;
    logic            op_write_q;
    logic            err_q;
    logic [BCW-1:0]  beat_q;
    logic [LCW-1:0]  lat_q;
    logic            resp_q;
    logic [63:0]     rdata_q;

    logic [63:0]     mem [DEPTH_LINES*BURST_LEN];

    logic [IDXW-1:0] cap_idx_d;
    logic            cap_err_d;
    logic [BCW-1:0]  beat_nxt_d;
    logic [IDXW-1:0] rd_idx_d;
    logic [BCW-1:0]  rd_beat_d;
    logic            rd_err_d;
    logic [63:0]     rdata_nxt_d;
    logic            mem_we_d;
    logic            unused_addr;

    function automatic logic [MEMW-1:0] beat_addr(input logic [IDXW-1:0] idx,
                                                   input logic [BCW-1:0]  beat);
        return MEMW'(idx) * MEMW'(BURST_LEN) + MEMW'(beat);
    endfunction

    assign cap_idx_d   = bmem_address[OFF +: IDXW];
    assign beat_nxt_d  = beat_q + 1'b1;
    assign unused_addr = ^bmem_address;

`ifdef BMEM_ADDR_CHECK_EN
    assign cap_err_d = |(bmem_address >> (OFF + IDXW));
    assign bmem_err  = resp_q & err_q;
`else
    assign cap_err_d = 1'b0;
    assign bmem_err  = 1'b0;
`endif

    // Single read port: look ahead to the beat that rdata_q will present next cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        rd_idx_d  = idx_q;
        rd_beat_d = '0;
        rd_err_d  = err_q;
        case (state_q)
            S_IDLE: begin
                rd_idx_d = cap_idx_d;
                rd_err_d = cap_err_d;
            end
            S_BURST: rd_beat_d = beat_nxt_d;
            default: ;
        endcase
        rdata_nxt_d = rd_err_d ? ERR_DATA : mem[beat_addr(rd_idx_d, rd_beat_d)];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            op_write_q <= 1'b0;
            err_q      <= 1'b0;
            beat_q     <= '0;
            lat_q      <= '0;
            resp_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    resp_q <= 1'b0;
                    if (bmem_read || bmem_write) begin
                        idx_q      <= cap_idx_d;
                        op_write_q <= !bmem_read;
                        err_q      <= cap_err_d;
                        beat_q     <= '0;
                        lat_q      <= '0;
                        if (LATENCY == 1) begin
                            state_q <= S_BURST;
                            resp_q  <= 1'b1;
                            if (bmem_read) rdata_q <= rdata_nxt_d;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (lat_q == LCW'(LATENCY - 2)) begin
                        state_q <= S_BURST;
                        resp_q  <= 1'b1;
                        if (!op_write_q) rdata_q <= rdata_nxt_d;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                S_BURST: begin
                    if (beat_q == BCW'(BURST_LEN - 1)) begin
                        state_q <= S_IDLE;
                        resp_q  <= 1'b0;
                    end else begin
                        beat_q <= beat_nxt_d;
                        if (!op_write_q) rdata_q <= rdata_nxt_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_we_d = !rst && (state_q == S_BURST) && op_write_q && !err_q;

    // NOTE: line storage has no reset so it maps onto RAM; a reset mid-burst leaves stored beats intact.
    always_ff @(posedge clk) begin
        if (mem_we_d) mem[beat_addr(idx_q, beat_q)] <= bmem_wdata;
    end

    assign bmem_resp  = resp_q;
    assign bmem_rdata = rdata_q;

endmodule

// File: tb/tb_bmem_responder.sv
// Directed bench for bmem_responder: default build plus a LATENCY=1 / BURST_LEN=1 instance.
module tb_bmem_responder;

    localparam int LAT = 4;
    localparam int BL  = 4;

    typedef logic [BL-1:0][63:0] line_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bmem_address;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic [63:0] bmem_rdata;
    logic        bmem_resp;
    logic        bmem_err;

    logic [31:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [63:0] s_wdata;
    logic [63:0] s_rdata;
    logic        s_resp;
    logic        s_err;

    int checks   = 0;
    int failures = 0;

    bmem_responder #(.LATENCY(LAT), .BURST_LEN(BL), .DEPTH_LINES(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .bmem_address (bmem_address),
        .bmem_read    (bmem_read),
        .bmem_write   (bmem_write),
        .bmem_wdata   (bmem_wdata),
        .bmem_rdata   (bmem_rdata),
        .bmem_resp    (bmem_resp),
        .bmem_err     (bmem_err)
    );

    bmem_responder #(.LATENCY(1), .BURST_LEN(1), .DEPTH_LINES(16)) dut_s (
        .clk          (clk),
        .rst          (rst),
        .bmem_address (s_address),
        .bmem_read    (s_read),
        .bmem_write   (s_write),
        .bmem_wdata   (s_wdata),
        .bmem_rdata   (s_rdata),
        .bmem_resp    (s_resp),
        .bmem_err     (s_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts in the request cycle T (just after a posedge); checks every cycle up to the last beat.
    task automatic burst(input string tag, input logic [31:0] addr, input logic rd, input logic wr,
                         input line_t wbeats, input line_t rbeats, input logic exp_err,
                         input int abort_at, input logic hold);
        bmem_address = addr;
        bmem_read    = rd;
        bmem_write   = wr;
        for (int c = 0; c < LAT + BL; c++) begin
            int k;
            k = c - LAT;
            bmem_wdata = (k >= 0) ? wbeats[k] : 64'h0;
            if (k == abort_at) rst = 1'b1;
            @(negedge clk);
            check($sformatf("%s:resp%0d", tag, c), 64'(bmem_resp), 64'(k >= 0));
            if (k >= 0) begin
                check($sformatf("%s:err%0d", tag, k), 64'(bmem_err), 64'(exp_err));
                if (rd) check($sformatf("%s:rdata%0d", tag, k), bmem_rdata, rbeats[k]);
            end
            @(posedge clk);
            #1;
            if (rst) begin
                rst        = 1'b0;
                bmem_read  = 1'b0;
                bmem_write = 1'b0;
                @(negedge clk);
                check({tag, ":resp_after_rst"}, 64'(bmem_resp), 64'h0);
                @(posedge clk);
                #1;
                return;
            end
        end
        if (hold) return;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        @(negedge clk);
        check({tag, ":resp_idle"}, 64'(bmem_resp), 64'h0);
        if (rd) check({tag, ":rdata_hold"}, bmem_rdata, rbeats[BL-1]);
        @(posedge clk);
        #1;
    endtask

    // Single-beat, LATENCY=1 instance: resp in the cycle right after capture.
    task automatic s_xfer(input string tag, input logic [31:0] addr, input logic wr,
                          input logic [63:0] data);
        s_address = addr;
        s_read    = !wr;
        s_write   = wr;
        s_wdata   = data;
        @(negedge clk);
        check({tag, ":resp_T"}, 64'(s_resp), 64'h0);
        @(posedge clk);
        #1;
        s_read  = 1'b0;
        s_write = 1'b0;
        @(negedge clk);
        check({tag, ":resp_T1"}, 64'(s_resp), 64'h1);
        check({tag, ":err"}, 64'(s_err), 64'h0);
        if (!wr) check({tag, ":rdata"}, s_rdata, data);
        @(posedge clk);
        #1;
        s_wdata = 64'h0;
        @(negedge clk);
        check({tag, ":resp_T2"}, 64'(s_resp), 64'h0);
        if (!wr) check({tag, ":rdata_hold"}, s_rdata, data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        line_t zero_l, l100, l40, junk, l200a, l200b, l200mix, l0, ldead;
        zero_l  = '0;
        l100    = {64'h44, 64'h33, 64'h22, 64'h11};
        l40     = {64'hA4, 64'hA3, 64'hA2, 64'hA1};
        junk    = {64'hFF04, 64'hFF03, 64'hFF02, 64'hFF01};
        l200a   = {64'hB4, 64'hB3, 64'hB2, 64'hB1};
        l200b   = {64'hC4, 64'hC3, 64'hC2, 64'hC1};
        l200mix = {64'hB4, 64'hB3, 64'hC2, 64'hC1};
        l0      = {64'hD4, 64'hD3, 64'hD2, 64'hD1};
        ldead   = {4{64'hDEAD_BEEF_DEAD_BEEF}};

        rst          = 1'b1;
        bmem_address = '0;
        bmem_read    = 1'b0;
        bmem_write   = 1'b0;
        bmem_wdata   = '0;
        s_address    = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_wdata      = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset:resp",    64'(bmem_resp), 64'h0);
        check("reset:rdata",   bmem_rdata,     64'h0);
        check("reset:err",     64'(bmem_err),  64'h0);
        check("reset:s_resp",  64'(s_resp),    64'h0);
        check("reset:s_rdata", s_rdata,        64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write then read back line 0x100.
        burst("wr100", 32'h100, 1'b0, 1'b1, l100, zero_l, 1'b0, 99, 1'b0);
        burst("rd100", 32'h100, 1'b1, 1'b0, zero_l, l100, 1'b0, 99, 1'b0);

        // Read held past the last beat is re-captured immediately.
        burst("rd100_b2b_a", 32'h100, 1'b1, 1'b0, zero_l, l100, 1'b0, 99, 1'b1);
        burst("rd100_b2b_b", 32'h100, 1'b1, 1'b0, zero_l, l100, 1'b0, 99, 1'b0);

        // Simultaneous read and write: read wins, storage untouched.
        burst("wr40",    32'h40, 1'b0, 1'b1, l40,  zero_l, 1'b0, 99, 1'b0);
        burst("rdwr40",  32'h40, 1'b1, 1'b1, junk, l40,    1'b0, 99, 1'b0);
        burst("rd40",    32'h40, 1'b1, 1'b0, zero_l, l40,  1'b0, 99, 1'b0);

        // Reset during beat 2 of a write keeps beats 0 and 1 only.
        burst("wr200_old", 32'h200, 1'b0, 1'b1, l200a, zero_l, 1'b0, 99, 1'b0);
        burst("wr200_rst", 32'h200, 1'b0, 1'b1, l200b, zero_l, 1'b0, 2,  1'b0);
        burst("rd200",     32'h200, 1'b1, 1'b0, zero_l, l200mix, 1'b0, 99, 1'b0);

        // Address bits above the index field.
        burst("wr0", 32'h0, 1'b0, 1'b1, l0, zero_l, 1'b0, 99, 1'b0);
`ifdef BMEM_ADDR_CHECK_EN
        burst("rd2000", 32'h2000, 1'b1, 1'b0, zero_l, ldead, 1'b1, 99, 1'b0);
        burst("wr2000", 32'h2000, 1'b0, 1'b1, junk, zero_l, 1'b1, 99, 1'b0);
        burst("rd0",    32'h0,    1'b1, 1'b0, zero_l, l0,    1'b0, 99, 1'b0);
`else
        burst("rd2000", 32'h2000, 1'b1, 1'b0, zero_l, l0, 1'b0, 99, 1'b0);
`endif

        // LATENCY=1, BURST_LEN=1 instance (8-byte lines).
        s_xfer("s_wr18", 32'h18, 1'b1, 64'hCAFE_0001);
        s_xfer("s_wr20", 32'h20, 1'b1, 64'hBEEF_0002);
        s_xfer("s_rd18", 32'h18, 1'b0, 64'hCAFE_0001);
        s_xfer("s_rd20", 32'h20, 1'b0, 64'hBEEF_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
